// File: rtl/settings_bus_arbiter_pkg.sv
// Shared definitions for the game-settings bus arbiter and its clients.
package settings_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } arb_state_t;

    localparam logic [15:0] WB_ERR_DATA = 16'hDEAD;

    // Settings register map, shared by requesters and the slave
    localparam logic [7:0] REG_DIFFICULTY   = 8'h00;
    localparam logic [7:0] REG_ROWS         = 8'h02;
    localparam logic [7:0] REG_COLS         = 8'h04;
    localparam logic [7:0] REG_MINES        = 8'h06;
    localparam logic [7:0] REG_TIME_LIMIT   = 8'h08;
    localparam logic [7:0] REG_SEED         = 8'h0A;
    localparam logic [7:0] REG_HIGH_SCORE   = 8'h0C;
    localparam logic [7:0] REG_GAMES_PLAYED = 8'h0E;
    localparam logic [7:0] REG_GAMES_WON    = 8'h10;

endpackage

// File: rtl/settings_bus_arbiter_if.sv
// Pipelined Wishbone read port between the arbiter and the settings slave.
interface wishbone_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              stb_o;
    logic              we_o;
    logic [ADDR_W-1:0] adr_o;
    logic              ack_i;
    logic              stall_i;
    logic [DATA_W-1:0] dat_i;

    modport master (
        output stb_o, we_o, adr_o,
        input  ack_i, stall_i, dat_i
    );

    modport slave (
        input  stb_o, we_o, adr_o,
        output ack_i, stall_i, dat_i
    );
endinterface

// File: rtl/settings_bus_arbiter_rr_picker.sv
// Round-robin selector: first set request above last_grant, wrapping.
module rr_picker #(
    parameter int N_REQ = 3,
    localparam int GW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last_grant,
    output logic             any,
    output logic [GW-1:0]    next_grant
);

    always_comb begin
        logic found;
        int   idx;
        any        = |req;
        next_grant = last_grant;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req[idx]) begin
                next_grant = GW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Serialises settings-register reads from several clients onto one
// Wishbone master port and routes each reply back to its requester.
module settings_bus_arbiter
    import settings_bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15,
    localparam int GW = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*ADDR_W-1:0] req_adr_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_data_o,
    output logic                    rsp_err_o,
    output logic [GW-1:0]           grant_o,
    wishbone_if.master              game_settings
);

    arb_state_t  state;
    logic [GW-1:0] last_grant;
    logic [7:0]  timer;
    logic        any;
    logic [GW-1:0] next_grant;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (req_i),
        .last_grant (last_grant),
        .any        (any),
        .next_grant (next_grant)
    );

    // The port is read-only
    assign game_settings.we_o = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            game_settings.stb_o <= 1'b0;
            game_settings.adr_o <= '0;
            rsp_valid_o         <= '0;
            rsp_data_o          <= '0;
            rsp_err_o           <= 1'b0;
            grant_o             <= '0;
            last_grant          <= GW'(N_REQ - 1);
            timer               <= '0;
        end else begin
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        grant_o             <= next_grant;
                        game_settings.adr_o <=
                            req_adr_i[int'(next_grant)*ADDR_W +: ADDR_W];
                        game_settings.stb_o <= 1'b1;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A stalled slave (menu mode) holds us here without timeout
                    if (!game_settings.stall_i) begin
                        game_settings.stb_o <= 1'b0;
                        timer               <= '0;
                        state               <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (game_settings.ack_i) begin
                        rsp_valid_o <= N_REQ'(1) << grant_o;
                        rsp_data_o  <= game_settings.dat_i;
                        last_grant  <= grant_o;
                        state       <= IDLE;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        rsp_valid_o <= N_REQ'(1) << grant_o;
                        rsp_data_o  <= DATA_W'(WB_ERR_DATA);
                        rsp_err_o   <= 1'b1;
                        last_grant  <= grant_o;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Directed bench for settings_bus_arbiter with a scoreboard of replies.
module tb_settings_bus_arbiter;
    import settings_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] req_adr;
    logic [2:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  grant;

    wishbone_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    settings_bus_arbiter #(
        .N_REQ(3), .ADDR_W(8), .DATA_W(16), .TIMEOUT(15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .req_adr_i    (req_adr),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .grant_o      (grant),
        .game_settings(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  vld;
        logic [15:0] dat;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   rc[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stb_hi = 0;
    int   acc_cyc = 0;
    int   rsp_cyc = 0;
    int   rsp_cnt = 0;
    int   last_rsp_grant = 0;

    // Slave model
    logic       ack_en;
    int         lat;
    logic       pend;
    int         cnt;
    logic [7:0] padr;

    function automatic logic [15:0] reg_val(logic [7:0] a);
        return {8'h00, a} * 16'd5;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack_i <= 1'b0;
            bus.dat_i <= '0;
            pend      <= 1'b0;
            cnt       <= 0;
            padr      <= '0;
        end else begin
            bus.ack_i <= 1'b0;
            if (bus.stb_o && !bus.stall_i) begin
                if (lat == 0 && ack_en) begin
                    bus.ack_i <= 1'b1;
                    bus.dat_i <= reg_val(bus.adr_o);
                    pend      <= 1'b0;
                end else begin
                    pend <= 1'b1;
                    cnt  <= lat;
                    padr <= bus.adr_o;
                end
            end else if (pend && ack_en) begin
                if (cnt <= 1) begin
                    bus.ack_i <= 1'b1;
                    bus.dat_i <= reg_val(padr);
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    push_exp_unused_guard: assert property (@(posedge clk) 1'b1);

    task automatic push(logic [2:0] v, logic [15:0] d, logic e);
        exp_t x;
        x.vld = v;
        x.dat = d;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_sb(string tag, int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Response monitor and scoreboard pop
    always @(negedge clk) begin
        exp_t e;
        if (bus.stb_o) stb_hi++;
        if (bus.stb_o && !bus.stall_i) acc_cyc = cyc;
        if (rsp_valid != 3'b000) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            last_rsp_grant = int'(grant);
            rc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                check("rsp_data", 32'(rsp_data), 32'(e.dat));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int rc0;
        int bad;
        int a0;
        int n;
        rst         = 1'b1;
        req         = 3'b000;
        req_adr     = {REG_MINES, REG_COLS, REG_ROWS};
        bus.stall_i = 1'b0;
        ack_en      = 1'b1;
        lat         = 0;
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(bus.stb_o), 32'h0);
        check("rst_we", 32'(bus.we_o), 32'h0);
        check("rst_adr", 32'(bus.adr_o), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_data", 32'(rsp_data), 32'h0);
        check("rst_err", 32'(rsp_err), 32'h0);
        rst = 1'b0;

        // Fairness from reset: 0,1,2,0,1,2
        @(negedge clk);
        rc.delete();
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: push(3'b001, reg_val(REG_ROWS), 1'b0);
                1: push(3'b010, reg_val(REG_COLS), 1'b0);
                default: push(3'b100, reg_val(REG_MINES), 1'b0);
            endcase
        end
        wait_sb("fair_done", 100);
        req = 3'b000;
        check("fair_count", rc.size(), 6);
        for (int i = 1; i < 6 && i < rc.size(); i++)
            check("fair_gap", rc[i] - rc[i-1], 3);

        // Single read latency and strobe width
        @(negedge clk);
        t0 = cyc;
        stb_hi = 0;
        req = 3'b001;
        push(3'b001, 16'd10, 1'b0);
        wait_sb("single_done", 20);
        req = 3'b000;
        check("single_lat", rsp_cyc - t0, 3);
        check("single_stb", stb_hi, 1);

        // Stalled slave
        @(negedge clk);
        bus.stall_i = 1'b1;
        req = 3'b010;
        push(3'b010, reg_val(REG_COLS), 1'b0);
        rc0 = rsp_cnt;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.stb_o !== 1'b1 || bus.adr_o !== REG_COLS) bad++;
        end
        check("stall_stb_adr", bad, 0);
        check("stall_no_rsp", rsp_cnt - rc0, 0);
        t0 = cyc;
        bus.stall_i = 1'b0;
        wait_sb("stall_done", 20);
        req = 3'b000;
        check("stall_lat", rsp_cyc - t0, 2);

        // Timeout, then a normal read (stale ack must be ignored)
        @(negedge clk);
        ack_en = 1'b0;
        req = 3'b001;
        push(3'b001, WB_ERR_DATA, 1'b1);
        wait_sb("to_done", 60);
        req = 3'b000;
        check("to_lat", rsp_cyc - acc_cyc, 16);
        @(negedge clk);
        t0 = cyc;
        ack_en = 1'b1;
        req = 3'b100;
        push(3'b100, reg_val(REG_MINES), 1'b0);
        wait_sb("after_to_done", 20);
        req = 3'b000;
        check("after_to_lat", rsp_cyc - t0, 3);

        // Reset during WAIT_ACK
        @(negedge clk);
        ack_en = 1'b0;
        req = 3'b100;
        repeat (5) @(negedge clk);
        #1;
        rc0 = rsp_cnt;
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        check("mid_rst_stb", 32'(bus.stb_o), 32'h0);
        check("mid_rst_adr", 32'(bus.adr_o), 32'h0);
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_data", 32'(rsp_data), 32'h0);
        check("mid_rst_err", 32'(rsp_err), 32'h0);
        #1;
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_rsp", rsp_cnt - rc0, 0);

        // Requester 1 read so last_grant moves off 2
        #1;
        req = 3'b010;
        push(3'b010, reg_val(REG_COLS), 1'b0);
        wait_sb("pre_drop_done", 20);
        req = 3'b000;

        // Requester 2 drops its request while waiting for ack
        @(negedge clk);
        lat = 3;
        a0 = acc_cyc;
        req = 3'b100;
        push(3'b100, reg_val(REG_MINES), 1'b0);
        n = 0;
        while (acc_cyc == a0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drop_accept", 32'(acc_cyc != a0), 32'h1);
        @(negedge clk);
        #1;
        req = 3'b000;
        wait_sb("drop_done", 30);
        check("drop_grant", last_rsp_grant, 2);
        lat = 0;

        // last_grant is now 2, so requester 0 wins next
        @(negedge clk);
        req = 3'b111;
        push(3'b001, reg_val(REG_ROWS), 1'b0);
        wait_sb("post_drop_done", 20);
        req = 3'b000;

        repeat (5) @(negedge clk);
        check("sb_empty_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/settings_bus_arbiter.md
# settings_bus_arbiter

Round-robin arbiter that shares the single read-only game-settings Wishbone slave between several requesters: board renderer, mine generator, timer and stats display. It serialises their register reads, drives the bus as master, and returns each read word, with an error flag on timeout, to the requester that asked. It sits between the game-setup FSM's `game_settings` slave port and the consumer blocks.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `ADDR_W`, 8: register address width.
- `DATA_W`, 16: data width.
- `TIMEOUT`, 15: max cycles in WAIT_ACK before an error response (1..255).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_i`  in  N_REQ  per-requester read request; level, held until the matching `rsp_valid_o` bit.
- `req_adr_i`  in  N_REQ×ADDR_W  per-requester address (packed); sampled at grant.
- `rsp_valid_o`  out  N_REQ  one-cycle response pulse, one-hot.
- `rsp_data_o`  out  DATA_W  response word; valid only while any `rsp_valid_o` bit is high.
- `rsp_err_o`  out  1  qualifies `rsp_valid_o`; high when the read timed out.
- `grant_o`  out  $clog2(N_REQ)  index of the current or last granted requester (debug).
- `game_settings`  wishbone_if.master  stb_o, we_o, adr_o driven; ack_i, dat_i, stall_i sampled.

## Operation
States: IDLE, ISSUE, WAIT_ACK.

- **IDLE**
  - stb_o=0.
  - If any `req_i` bit is set, pick the first set bit searching upward cyclically from `last_grant+1`.
  - Latch that requester's index into `grant` and its address into `adr_o`, then go to ISSUE.
- **ISSUE**
  - stb_o=1, we_o=0, adr_o held.
  - On a clock edge with stall_i=0, the request is accepted: go to WAIT_ACK, stb_o=0 next cycle, timer=0.
  - While stall_i=1 (game in MENU), stay in ISSUE indefinitely with stb_o held. No timeout applies here.
- **WAIT_ACK**
  - Timer increments each cycle.
  - ack_i=1: the next cycle pulses `rsp_valid_o[grant]`, `rsp_data_o`=dat_i, `rsp_err_o`=0. Set `last_grant`=grant and go to IDLE.
  - Otherwise, when timer reaches TIMEOUT-1: pulse `rsp_valid_o[grant]` with `rsp_data_o`=16'hDEAD and `rsp_err_o`=1, then go to IDLE.
  - ack_i and timeout on the same edge: ack wins.

Boundary rules:
- A requester that drops `req_i` mid-transaction still receives its pulse. It may ignore it, and no abort is issued.
- A requester that keeps `req_i` high after its response re-enters arbitration at lowest priority relative to the others.
- `rsp_valid_o` bits are never asserted simultaneously.
- At most one bus transaction is outstanding.
- ack_i arriving outside WAIT_ACK is ignored.
- Address decode and the 16'hDEAD default for unmapped addresses belong to the slave. The arbiter passes data through unchanged.

## Timing
- Reset values:
  - state=IDLE, stb_o=0, we_o=0, adr_o=0.
  - rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0.
  - grant_o=0; `last_grant`=N_REQ-1, so requester 0 wins first.
  - timer=0.
- Reset mid-transaction: stb_o drops the next cycle, no response is pulsed, and pending requests are re-arbitrated from scratch.
- Latency, unstalled: req_i sampled at edge 0 → stb_o high in cycle 1 → slave ack_i registered in cycle 2 → rsp_valid_o in cycle 3. That is 3 cycles request-to-response.
- Back-to-back throughput: one read per 3 cycles. IDLE is always visited for one cycle between transactions.
- rsp_* outputs are registered.

## Structure
- game_pkg gains:
  - `arb_state_t` enum (IDLE, ISSUE, WAIT_ACK).
  - `WB_ERR_DATA`=16'hDEAD.
  - The settings register address constants (0x00..0x10), so requesters and the slave share one definition.
- Sub-module `rr_picker`: combinational. Inputs `req` and `last_grant`; outputs `any` and `next_grant`. Parameterised by N_REQ.
- Top-level contains the FSM, the timer and the response registers.

## Test plan
- **Single read.** stall_i=0, req_i=3'b001, adr=8'h02, slave returns 16'd10 → `rsp_valid_o`=3'b001 exactly 3 cycles after req, data 10, err 0, stb_o high for exactly 1 cycle.
- **Fairness.** req_i=3'b111 held continuously → grants in order 0,1,2,0,1,2, with one response per 3 cycles and each address matching its requester.
- **Stall.** stall_i=1 for 20 cycles with req_i=3'b010 → stb_o stays high with adr stable and no response. After stall_i falls, the response arrives 2 cycles later.
- **Timeout.** Slave never acks, TIMEOUT=15 → `rsp_valid_o[grant]` with data 16'hDEAD and err=1, 15 cycles after acceptance. The next request then proceeds normally.
- **Reset mid-op.** rst asserted during WAIT_ACK → all outputs at reset values the next cycle, and no response pulse for the aborted read.
- **Dropped request.** Requester 2 deasserts req_i in WAIT_ACK → it still gets its pulse, and `last_grant` becomes 2.
